// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display scanner.
package display_pkg;

  // Width of one hex digit on the decoder interface.
  localparam int NIBBLE_W = 4;

  // Largest supported digit count; sizes the one-hot helper result.
  localparam int MAX_DIGITS = 8;

  // Scan phases: dark between frames, dark gap at slot start, digit lit.
  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  // One-hot digit enable for index idx; all zero when idx is outside 0..digits-1.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx,
                                                   input int unsigned digits);
    logic [MAX_DIGITS-1:0] r;
    r = '0;
    if ({29'd0, idx} < digits) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/display_scanner_slot_timer.sv
// Per-slot cycle counter: counts 0..DIGIT_CYCLES-1 while running and flags
// the last blank cycle and the last cycle of the slot.
module slot_timer #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic clk,
  input  logic rstN,
  input  logic run,
  output logic blankEnd,
  output logic slotEnd
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Slot counter: held at 0 while idle, wraps at the end of every slot.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create simulation order races.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt <= '0;
    end else if (!run || slotEnd) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign blankEnd = run && (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign slotEnd  = run && (cnt == CNT_W'(DIGIT_CYCLES - 1));

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexes a DIGITS-wide hex value onto a shared 7-segment bus with a
// blanking gap at the start of each digit slot and frame-aligned value updates.
module display_scanner
  import display_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 64,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         enable,
  input  logic [NIBBLE_W*DIGITS-1:0]   value,
  input  logic                         valueLoad,
  output logic [NIBBLE_W-1:0]          number,
  output logic [DIGITS-1:0]            digitSel,
  output logic                         frameStart
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int VAL_W = NIBBLE_W * DIGITS;

  scan_state_t      state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             enter_blank;
  logic             enter_show;
  logic             frame_edge;
  logic             blank_end;
  logic             slot_end;

  logic [VAL_W-1:0]    pending;
  logic                pending_valid;
  logic [VAL_W-1:0]    shadow;
  logic [VAL_W-1:0]    shadow_nxt;
  logic [VAL_W-1:0]    upper;
  logic                lz_dark;
  logic [NIBBLE_W-1:0] number_nxt;
  logic [DIGITS-1:0]   show_sel;

  slot_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk      (clk),
    .rstN     (rstN),
    .run      (state != IDLE),
    .blankEnd (blank_end),
    .slotEnd  (slot_end)
  );

  // FSM state and digit index register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic; enable is only acted on at slot boundaries or from IDLE.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    enter_blank = 1'b0;
    enter_show  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nxt   = BLANK;
          idx_nxt     = '0;
          enter_blank = 1'b1;
        end
      end
      BLANK: begin
        if (blank_end) begin
          state_nxt  = SHOW;
          enter_show = 1'b1;
        end
      end
      SHOW: begin
        if (slot_end) begin
          if (enable) begin
            state_nxt   = BLANK;
            idx_nxt     = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            enter_blank = 1'b1;
          end else begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Frame boundary: a new slot 0 begins; the shadow may be refreshed here and
  // digit 0 must already see the refreshed value.
  always_comb begin
    frame_edge = enter_blank && (idx_nxt == '0);
    shadow_nxt = (frame_edge && pending_valid) ? pending : shadow;
    number_nxt = shadow_nxt[NIBBLE_W*int'(idx_nxt) +: NIBBLE_W];
  end

  // Leading-zero suppression: digit idx>0 stays dark when it and all higher
  // digits of the displayed value are zero.
  always_comb begin
    upper    = shadow >> (NIBBLE_W * int'(idx));
    lz_dark  = (LZ_SUPPRESS != 0) && (idx != '0) && (upper == '0);
    show_sel = lz_dark ? '0 : DIGITS'(onehot(3'(idx), DIGITS));
  end

  // Pending/shadow double buffer: loads land in pending, shadow changes only
  // at frame boundaries so a frame never mixes two values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pending       <= '0;
      pending_valid <= 1'b0;
      shadow        <= '0;
    end else begin
      if (frame_edge && pending_valid) begin
        shadow        <= pending;
        pending_valid <= 1'b0;
      end
      // NOTE: a strobe coincident with the transfer lands after it in this
      // block, so its non-blocking update wins and the new value stays pending.
      if (valueLoad) begin
        pending       <= value;
        pending_valid <= 1'b1;
      end
    end
  end

  // Registered decoder outputs: number is set on slot entry, digitSel changes
  // only at the BLANK->SHOW and slot-end boundaries.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      number     <= '0;
      digitSel   <= '0;
      frameStart <= 1'b0;
    end else begin
      frameStart <= frame_edge;
      if (enter_blank) begin
        number <= number_nxt;
      end
      if (enter_show) begin
        digitSel <= show_sel;
      end else if (state_nxt != SHOW) begin
        digitSel <= '0;
      end
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: a cycle-count based reference model
// (time since scan start, slot = time/DIGIT_CYCLES) plus scenario checks.
module tb_display_scanner;

  localparam int DIGITS = 4;
  localparam int DC     = 10;
  localparam int BC     = 2;
  localparam int FRAME  = DIGITS * DC;

  logic        clk       = 1'b0;
  logic        rstN      = 1'b0;
  logic        enable    = 1'b0;
  logic        valueLoad = 1'b0;
  logic [15:0] value     = 16'h0;
  logic [3:0]  number;
  logic [3:0]  digitSel;
  logic        frameStart;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_scanner #(
    .DIGITS       (DIGITS),
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC),
    .LZ_SUPPRESS  (1)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .enable     (enable),
    .value      (value),
    .valueLoad  (valueLoad),
    .number     (number),
    .digitSel   (digitSel),
    .frameStart (frameStart)
  );

  // Reference model: running flag, cycles since scan start, displayed/pending values.
  bit          m_run     = 1'b0;
  int          m_t       = 0;
  logic [15:0] m_shadow  = 16'h0;
  logic [15:0] m_pending = 16'h0;
  bit          m_pvalid  = 1'b0;
  logic [3:0]  m_num     = 4'h0;

  function automatic int cur_slot();
    return (m_t / DC) % DIGITS;
  endfunction

  function automatic int cur_pos();
    return m_t % FRAME;
  endfunction

  function automatic logic [3:0] exp_sel();
    int s;
    if (!m_run || (m_t % DC) < BC) return 4'b0000;
    s = cur_slot();
    if (s > 0 && (m_shadow >> (4 * s)) == 16'h0) return 4'b0000;
    return 4'(1 << s);
  endfunction

  function automatic logic exp_fs();
    return m_run && (m_t % FRAME == 0);
  endfunction

  always @(posedge clk or negedge rstN) begin : model
    bit frame;
    if (!rstN) begin
      m_run = 0; m_t = 0; m_shadow = 0; m_pending = 0; m_pvalid = 0; m_num = 0;
    end else begin
      frame = 0;
      if (!m_run) begin
        if (enable) begin
          m_run = 1; m_t = 0; frame = 1;
        end
      end else if ((m_t % DC) == DC - 1 && !enable) begin
        m_run = 0;
      end else begin
        m_t = m_t + 1;
        frame = (m_t % FRAME == 0);
      end
      if (frame && m_pvalid) begin
        m_shadow = m_pending;
        m_pvalid = 0;
      end
      if (valueLoad) begin
        m_pending = value;
        m_pvalid  = 1;
      end
      if (m_run) m_num = m_shadow[4*cur_slot() +: 4];
    end
  end

  task automatic test_reset();
    rstN = 1'b0; enable = 1'b0; valueLoad = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({digitSel, number, frameStart} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: sel=%b num=%h fs=%b, want all 0", digitSel, number, frameStart);
    end
    rstN = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({digitSel, number, frameStart} !== {exp_sel(), m_num, exp_fs()}) begin
        errors++;
        $display("FAIL reset_idle t=%0t: sel=%b num=%h fs=%b, want sel=%b num=%h fs=%b",
                 $time, digitSel, number, frameStart, exp_sel(), m_num, exp_fs());
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [3:0] tbl [4] = '{4'hF, 4'h3, 4'hA, 4'h1};
    int last_fs = -1;
    value = 16'h1A3F; valueLoad = 1'b1;
    @(negedge clk);
    valueLoad = 1'b0; enable = 1'b1;
    for (int c = 0; c < 2 * FRAME + 2; c++) begin
      @(negedge clk);
      checks++;
      if ({digitSel, number, frameStart} !== {exp_sel(), m_num, exp_fs()}) begin
        errors++;
        $display("FAIL basic_model t=%0t: sel=%b num=%h fs=%b, want sel=%b num=%h fs=%b",
                 $time, digitSel, number, frameStart, exp_sel(), m_num, exp_fs());
      end
      if (m_run && (m_t % DC) == BC) begin
        checks++;
        if (digitSel !== 4'(1 << cur_slot()) || number !== tbl[cur_slot()]) begin
          errors++;
          $display("FAIL basic_digit slot %0d: sel=%b num=%h, want sel=%b num=%h",
                   cur_slot(), digitSel, number, 4'(1 << cur_slot()), tbl[cur_slot()]);
        end
      end
      if (frameStart) begin
        if (last_fs >= 0) begin
          checks++;
          if (c - last_fs != FRAME) begin
            errors++;
            $display("FAIL basic_period: %0d cycles between frames, want %0d", c - last_fs, FRAME);
          end
        end
        last_fs = c;
      end
    end
  endtask

  task automatic test_midframe_load();
    int fr = 0;
    for (int c = 0; c < 4 * FRAME && fr < 3; c++) begin
      @(negedge clk);
      valueLoad = 1'b0;
      checks++;
      if ({digitSel, number, frameStart} !== {exp_sel(), m_num, exp_fs()}) begin
        errors++;
        $display("FAIL midload_model t=%0t: sel=%b num=%h fs=%b, want sel=%b num=%h fs=%b",
                 $time, digitSel, number, frameStart, exp_sel(), m_num, exp_fs());
      end
      if (frameStart) fr++;
      if (fr == 1 && cur_pos() == 2 * DC) begin
        value = 16'h1234; valueLoad = 1'b1;
      end
      if (fr >= 1 && fr <= 2 && cur_slot() == 2 && (m_t % DC) >= BC) begin
        checks++;
        if (number !== ((fr == 1) ? 4'hA : 4'h2)) begin
          errors++;
          $display("FAIL midload_digit2 frame %0d: num=%h, want %h", fr, number, (fr == 1) ? 4'hA : 4'h2);
        end
      end
    end
    checks++;
    if (fr < 3) begin
      errors++;
      $display("FAIL midload_timeout: saw %0d frames, want 3", fr);
    end
  endtask

  task automatic test_double_strobe();
    int fr = 0;
    logic [3:0] want;
    for (int c = 0; c < 6 * FRAME && fr < 5; c++) begin
      @(negedge clk);
      valueLoad = 1'b0;
      checks++;
      if ({digitSel, number, frameStart} !== {exp_sel(), m_num, exp_fs()}) begin
        errors++;
        $display("FAIL strobe_model t=%0t: sel=%b num=%h fs=%b, want sel=%b num=%h fs=%b",
                 $time, digitSel, number, frameStart, exp_sel(), m_num, exp_fs());
      end
      if (frameStart) fr++;
      if (fr == 1 && cur_pos() == DC)         begin value = 16'h1111; valueLoad = 1'b1; end
      if (fr == 1 && cur_pos() == 2 * DC)     begin value = 16'h2222; valueLoad = 1'b1; end
      if (fr == 2 && cur_pos() == DC)         begin value = 16'h4444; valueLoad = 1'b1; end
      if (fr == 2 && cur_pos() == FRAME - 1)  begin value = 16'h3333; valueLoad = 1'b1; end
      if (fr >= 2 && fr <= 4 && (m_t % DC) >= BC) begin
        want = (fr == 2) ? 4'h2 : (fr == 3) ? 4'h4 : 4'h3;
        checks++;
        if (number !== want || digitSel !== 4'(1 << cur_slot())) begin
          errors++;
          $display("FAIL strobe_frame %0d: num=%h sel=%b, want num=%h sel=%b",
                   fr, number, digitSel, want, 4'(1 << cur_slot()));
        end
      end
    end
    checks++;
    if (fr < 5) begin
      errors++;
      $display("FAIL strobe_timeout: saw %0d frames, want 5", fr);
    end
  endtask

  task automatic test_lz();
    int fr = 0;
    int last_fs = -1;
    logic [3:0] want_sel;
    for (int c = 0; c < 5 * FRAME && fr < 4; c++) begin
      @(negedge clk);
      valueLoad = 1'b0;
      checks++;
      if ({digitSel, number, frameStart} !== {exp_sel(), m_num, exp_fs()}) begin
        errors++;
        $display("FAIL lz_model t=%0t: sel=%b num=%h fs=%b, want sel=%b num=%h fs=%b",
                 $time, digitSel, number, frameStart, exp_sel(), m_num, exp_fs());
      end
      if (frameStart) begin
        fr++;
        if (last_fs >= 0) begin
          checks++;
          if (c - last_fs != FRAME) begin
            errors++;
            $display("FAIL lz_period: %0d cycles between frames, want %0d", c - last_fs, FRAME);
          end
        end
        last_fs = c;
      end
      if (fr == 1 && cur_pos() == DC) begin value = 16'h0005; valueLoad = 1'b1; end
      if (fr == 2 && cur_pos() == DC) begin value = 16'h0000; valueLoad = 1'b1; end
      if ((fr == 2 || fr == 3) && (m_t % DC) >= BC) begin
        want_sel = (cur_slot() == 0) ? 4'b0001 : 4'b0000;
        checks++;
        if (digitSel !== want_sel || (cur_slot() == 0 && number !== ((fr == 2) ? 4'h5 : 4'h0))) begin
          errors++;
          $display("FAIL lz_frame %0d slot %0d: sel=%b num=%h, want sel=%b",
                   fr, cur_slot(), digitSel, number, want_sel);
        end
      end
    end
    checks++;
    if (fr < 4) begin
      errors++;
      $display("FAIL lz_timeout: saw %0d frames, want 4", fr);
    end
  endtask

  task automatic test_enable_drop();
    int fr = 0;
    bit dropped = 0;
    value = 16'hBEEF; valueLoad = 1'b1;
    for (int c = 0; c < 3 * FRAME && !dropped; c++) begin
      @(negedge clk);
      valueLoad = 1'b0;
      checks++;
      if ({digitSel, number, frameStart} !== {exp_sel(), m_num, exp_fs()}) begin
        errors++;
        $display("FAIL drop_model t=%0t: sel=%b num=%h fs=%b, want sel=%b num=%h fs=%b",
                 $time, digitSel, number, frameStart, exp_sel(), m_num, exp_fs());
      end
      if (frameStart) fr++;
      if (fr >= 1 && cur_pos() == DC + BC) begin
        checks++;
        if (digitSel !== 4'b0010 || number !== 4'hE) begin
          errors++;
          $display("FAIL drop_digit1: sel=%b num=%h, want sel=0010 num=e", digitSel, number);
        end
        enable = 1'b0;
        dropped = 1;
      end
    end
    checks++;
    if (!dropped) begin
      errors++;
      $display("FAIL drop_timeout: never reached digit 1 show");
    end
    for (int c = 0; c < 3 * DC; c++) begin
      @(negedge clk);
      checks++;
      if ({digitSel, number, frameStart} !== {exp_sel(), m_num, exp_fs()}) begin
        errors++;
        $display("FAIL drop_tail t=%0t: sel=%b num=%h fs=%b, want sel=%b num=%h fs=%b",
                 $time, digitSel, number, frameStart, exp_sel(), m_num, exp_fs());
      end
    end
    checks++;
    if (digitSel !== 4'b0000 || frameStart !== 1'b0) begin
      errors++;
      $display("FAIL drop_dark: sel=%b fs=%b, want sel=0000 fs=0", digitSel, frameStart);
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (frameStart !== 1'b1 || digitSel !== 4'b0000 || number !== 4'hF) begin
      errors++;
      $display("FAIL reenable_start: fs=%b sel=%b num=%h, want fs=1 sel=0000 num=f",
               frameStart, digitSel, number);
    end
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      checks++;
      if ({digitSel, number, frameStart} !== {exp_sel(), m_num, exp_fs()}) begin
        errors++;
        $display("FAIL reenable_model t=%0t: sel=%b num=%h fs=%b, want sel=%b num=%h fs=%b",
                 $time, digitSel, number, frameStart, exp_sel(), m_num, exp_fs());
      end
    end
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    for (int c = 0; c < 2 * FRAME && !hit; c++) begin
      @(negedge clk);
      valueLoad = 1'b0;
      checks++;
      if ({digitSel, number, frameStart} !== {exp_sel(), m_num, exp_fs()}) begin
        errors++;
        $display("FAIL arst_model t=%0t: sel=%b num=%h fs=%b, want sel=%b num=%h fs=%b",
                 $time, digitSel, number, frameStart, exp_sel(), m_num, exp_fs());
      end
      if (cur_pos() == DC) begin value = 16'h7777; valueLoad = 1'b1; end
      if (cur_pos() == 2 * DC + 5) hit = 1;
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({digitSel, number, frameStart} !== 9'b0) begin
      errors++;
      $display("FAIL arst_immediate: sel=%b num=%h fs=%b, want all 0", digitSel, number, frameStart);
    end
    @(negedge clk);
    rstN = 1'b1;
    for (int c = 0; c < FRAME + 2; c++) begin
      @(negedge clk);
      checks++;
      if ({digitSel, number, frameStart} !== {exp_sel(), m_num, exp_fs()}) begin
        errors++;
        $display("FAIL arst_after t=%0t: sel=%b num=%h fs=%b, want sel=%b num=%h fs=%b",
                 $time, digitSel, number, frameStart, exp_sel(), m_num, exp_fs());
      end
      if (m_run && (m_t % DC) >= BC) begin
        checks++;
        if (number !== 4'h0 || digitSel !== ((cur_slot() == 0) ? 4'b0001 : 4'b0000)) begin
          errors++;
          $display("FAIL arst_shadow slot %0d: sel=%b num=%h, want num=0 and only digit 0 lit",
                   cur_slot(), digitSel, number);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      checks++;
      if ({digitSel, number, frameStart} !== {exp_sel(), m_num, exp_fs()}) begin
        errors++;
        $display("FAIL random_model t=%0t: sel=%b num=%h fs=%b, want sel=%b num=%h fs=%b",
                 $time, digitSel, number, frameStart, exp_sel(), m_num, exp_fs());
      end
      valueLoad = ($urandom_range(0, 15) == 0);
      value     = 16'($urandom >> $urandom_range(0, 16));
      if ($urandom_range(0, 59) == 0) enable = ~enable;
    end
    valueLoad = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_midframe_load();
    test_double_strobe();
    test_lz();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
